// File: rtl/siha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : siha_pkg                                                         |
// | Brief   : Shared SIHA slot sequencer state encoding.                       |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package siha_pkg;

  localparam int SEQ_STATE_W = 3;

  localparam logic [2:0] SEQ_OFF    = 3'd0;
  localparam logic [2:0] SEQ_CLK_ON = 3'd1;
  localparam logic [2:0] SEQ_ARMED  = 3'd2;
  localparam logic [2:0] SEQ_RUN    = 3'd3;
  localparam logic [2:0] SEQ_DRAIN  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/slot_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : slot_reset_sequencer                                             |
// | Brief   : Per-RP-slot clock-enable/reset sequencer. Optional arm timeout   |
// |           enabled by defining SLOT_SEQ_TIMEOUT_EN.                         |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module slot_reset_sequencer
  import siha_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_clken,
  input  logic                   req_resetn,
  input  logic                   clk_locked,
  input  logic                   decouple_status,
  output logic                   rp_clken,
  output logic                   rp_resetn,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic                   busy,
  output logic                   err
);

  localparam int               CNT_W      = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(RST_CYCLES - 1);

  logic [SEQ_STATE_W-1:0] r_state;
  logic [CNT_W-1:0]       r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= SEQ_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        SEQ_OFF: begin
          if (req_clken && clk_locked) begin
            r_state <= SEQ_CLK_ON;
            r_cnt   <= C_CNT_LOAD;
          end
        end
        SEQ_CLK_ON: begin
          // A lock loss restarts the hold so reset spans RST_CYCLES stable clocks
          if (!req_clken)
            r_state <= SEQ_OFF;
          else if (!clk_locked)
            r_cnt <= C_CNT_LOAD;
          else if (r_cnt == '0)
            r_state <= SEQ_ARMED;
          else
            r_cnt <= r_cnt - CNT_W'(1);
        end
        SEQ_ARMED: begin
          if (!req_clken)
            r_state <= SEQ_OFF;
          else if (req_resetn && clk_locked && !decouple_status)
            r_state <= SEQ_RUN;
        end
        SEQ_RUN: begin
          if (!req_clken || !req_resetn || !clk_locked || decouple_status) begin
            r_state <= SEQ_DRAIN;
            r_cnt   <= C_CNT_LOAD;
          end
        end
        SEQ_DRAIN: begin
          if (r_cnt == '0)
            r_state <= SEQ_ARMED;
          else
            r_cnt <= r_cnt - CNT_W'(1);
        end
        default: r_state <= SEQ_OFF;
      endcase
    end
  end

  assign rp_clken  = (r_state == SEQ_CLK_ON) || (r_state == SEQ_ARMED) ||
                     (r_state == SEQ_RUN)    || (r_state == SEQ_DRAIN);
  assign rp_resetn = (r_state == SEQ_RUN);
  assign busy      = (r_state == SEQ_CLK_ON) || (r_state == SEQ_DRAIN);
  assign seq_state = r_state;

`ifdef SLOT_SEQ_TIMEOUT_EN
  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] C_TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic             w_tmo_run;

  // Software wants release but the slot cannot leave ARMED
  assign w_tmo_run = (r_state == SEQ_ARMED) && req_resetn && (decouple_status || !clk_locked);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_tmo_run)
        r_tmo <= '0;
      else if (r_tmo != C_TMO_MAX)
        r_tmo <= r_tmo + TMO_W'(1);

      if (!req_resetn)
        r_err <= 1'b0;
      else if (w_tmo_run && (r_tmo == C_TMO_LAST))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire
